// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and state encodings for the FIFO family.
package fifo_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic {IDLE, SEND} rd_state_e;
endpackage

// File: rtl/fifo_reader.sv
// fifo_reader: pops FWFT FIFO words and streams them out LSB byte first over valid/ready.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int B     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             empty,
  output logic             rd,
  input  logic [B-1:0]     rd_data,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);
  localparam int NB = B / BYTE_W;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  rd_state_e        state_q, state_d;
  logic [B-1:0]     sr_q, sr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc, last;
  assign acc  = (state_q == SEND) && m_ready;
  assign last = idx_q == IW'(NB - 1);
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (empty ? IDLE : SEND)
                                : ((acc && last && empty) ? IDLE : SEND);
  end
  // A pop happens from IDLE or on the last byte, so back-to-back words have no bubble.
  always_comb begin
    rd       = !reset && !empty && (state_q == IDLE || (acc && last));
    m_valid  = state_q == SEND;
    busy     = state_q == SEND;
    m_data   = sr_q[BYTE_W-1:0];
    word_cnt = cnt_q;
  end
  always_comb begin
    sr_d  = rd ? rd_data : (acc ? sr_q >> BYTE_W : sr_q);
    idx_d = rd ? '0 : (acc ? idx_q + 1'b1 : idx_q);
    cnt_d = cnt_q + CNT_W'(acc && last);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: scoreboard bench pairing fifo_reader with a 4-deep 32-bit FWFT FIFO model.
module tb_fifo_reader;
  logic        clk = 0;
  logic        reset = 1;
  logic        empty, rd, m_valid, m_ready = 0, busy;
  logic [31:0] rd_data;
  logic [7:0]  m_data;
  logic [15:0] word_cnt;
  logic        wr = 0;
  logic [31:0] wr_data = '0;
  logic [31:0] mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  fcnt;
  int          pass = 0, total = 0;
  int          rd_cnt = 0, acc_cnt = 0, val_cnt = 0;
  logic        prev_stall = 0;
  logic [7:0]  prev_data = '0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  fifo_reader #(.B(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .empty(empty), .rd(rd), .rd_data(rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .word_cnt(word_cnt)
  );

  assign empty   = fcnt == 0;
  assign rd_data = mem[rp];

  always @(posedge clk) begin
    if (reset) begin
      wp <= 0; rp <= 0; fcnt <= 0;
    end else begin
      if (wr && fcnt < 4) begin
        mem[wp] <= wr_data;
        wp <= wp + 1;
      end
      if (rd) rp <= rp + 1;
      fcnt <= fcnt + 3'(wr && fcnt < 4) - 3'(rd);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: scoreboard pops, stall stability, and rd protocol, all sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (rd) begin
        rd_cnt++;
        check("rd_while_empty", empty, 0);
      end
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
      end
      if (m_valid) val_cnt++;
      if (m_valid && m_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) check("unexpected_byte", m_data, 'x);
        else check("byte", m_data, exp_q.pop_front());
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    wr = 1;
    wr_data = w;
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    step();
    wr = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    m_ready = 0;
    wr = 0;
    exp_q.delete();
    step();
    step();
    reset = 0;
    rd_cnt = 0;
    acc_cnt = 0;
    val_cnt = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || fcnt != 0 || exp_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    step();
    step();
    check("rst_rd", rd, 0);
    reset = 0;
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_cnt", word_cnt, 0);
    check("rst_busy", busy, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_rd", rd, 0);
      check("idle_valid", m_valid, 0);
    end
    apply_reset();
    m_ready = 1;
    push(32'hdeadbeef);
    wait_idle("single");
    check("single_cnt", word_cnt, 1);
    check("single_rd", rd_cnt, 1);
    check("single_vcycles", val_cnt, 4);
    check("single_busy", busy, 0);
    apply_reset();
    m_ready = 1;
    push(32'h03020100);
    push(32'h07060504);
    wait_idle("pair");
    check("pair_cnt", word_cnt, 2);
    check("pair_vcycles", val_cnt, 8);
    check("pair_rd", rd_cnt, 2);
    apply_reset();
    push(32'h12345678);
    begin
      int n = 0;
      while (!m_valid && n < 20) begin
        step();
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_hold_valid", m_valid, 1);
      check("stall_hold_data", m_data, 8'h78);
      step();
    end
    m_ready = 1;
    wait_idle("stall");
    check("stall_cnt", word_cnt, 1);
    apply_reset();
    m_ready = 1;
    push(32'haabbccdd);
    begin
      int n = 0;
      while (acc_cnt < 2 && n < 20) begin
        step();
        n++;
      end
      check("mid_acc", acc_cnt, 2);
    end
    reset = 1;
    exp_q.delete();
    step();
    reset = 0;
    check("mid_valid", m_valid, 0);
    check("mid_cnt", word_cnt, 0);
    push(32'h11223344);
    wait_idle("restart");
    check("restart_cnt", word_cnt, 1);
    apply_reset();
    for (int i = 0; i < 4; i++) push(32'(i));
    m_ready = 1;
    wait_idle("burst");
    check("burst_rd", rd_cnt, 4);
    check("burst_cnt", word_cnt, 4);
    check("burst_empty", empty, 1);
    check("burst_busy", busy, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
